// File: rtl/ibex_irq_x_ctrl.sv
// ibex_irq_x_ctrl: per-source level/edge interrupt latch driving the core's irq_x_i vector.
// Optional macro IBEX_IRQ_X_SYNC_EN adds a 2-flop synchronizer on every src_i bit.
module ibex_irq_x_ctrl #(
    parameter int unsigned NumSrc   = 16,
    parameter logic [15:0] EdgeMask = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] src_i,
    input  logic [NumSrc-1:0] enable_i,
    output logic [31:0]       irq_x_o,
    input  logic              irq_x_ack_i,
    input  logic [3:0]        irq_x_ack_id_i,
    output logic              ack_err_o,
    output logic              pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_e;

    irq_state_e        state_q [NumSrc];
    logic [NumSrc-1:0] s_s;
    logic [NumSrc-1:0] s_prev_q;
    logic [NumSrc-1:0] rise_s;
    logic [NumSrc-1:0] is_pend_s;
    logic [NumSrc-1:0] ack_hit_s;
    logic              ack_err_q;

`ifdef IBEX_IRQ_X_SYNC_EN
    logic [NumSrc-1:0] sync_q1;
    logic [NumSrc-1:0] sync_q2;

    // Two-flop synchronizer so peripherals may drive src_i asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= {NumSrc{1'b0}};
            sync_q2 <= {NumSrc{1'b0}};
        end else begin
            sync_q1 <= src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign s_s = sync_q2;
`else
    assign s_s = src_i;
`endif

    // Previous conditioned level; resets low so a line high out of reset is an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_prev_q <= {NumSrc{1'b0}};
        end else begin
            s_prev_q <= s_s;
        end
    end

    assign rise_s = s_s & ~s_prev_q;

    // Decode which source (if any) a valid acknowledge retires.
    always_comb begin
        is_pend_s = {NumSrc{1'b0}};
        ack_hit_s = {NumSrc{1'b0}};
        for (int i = 0; i < int'(NumSrc); i++) begin
            is_pend_s[i] = (state_q[i] == ST_PENDING);
            ack_hit_s[i] = irq_x_ack_i && (irq_x_ack_id_i == 4'(i)) && is_pend_s[i];
        end
    end

    // Per-source request FSMs plus the registered ack error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSrc); i++) begin
                state_q[i] <= ST_IDLE;
            end
            ack_err_q <= 1'b0;
        end else begin
            // Out-of-range IDs never hit, so they fall into the error case too.
            ack_err_q <= irq_x_ack_i & ~(|ack_hit_s);
            for (int i = 0; i < int'(NumSrc); i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if ((EdgeMask[i] ? rise_s[i] : s_s[i]) && enable_i[i]) begin
                            state_q[i] <= ST_PENDING;
                        end else begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    ST_PENDING: begin
                        if (!ack_hit_s[i]) begin
                            state_q[i] <= ST_PENDING;
                        end else if (!EdgeMask[i]) begin
                            state_q[i] <= ST_SERVICE;
                        end else if (rise_s[i] && enable_i[i]) begin
                            // A fresh edge coincident with its ack keeps the request alive.
                            state_q[i] <= ST_PENDING;
                        end else begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    ST_SERVICE: begin
                        if (!s_s[i]) begin
                            state_q[i] <= ST_IDLE;
                        end else begin
                            state_q[i] <= ST_SERVICE;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Present enabled pending sources; upper bits stay zero.
    always_comb begin
        irq_x_o = 32'h0000_0000;
        for (int i = 0; i < int'(NumSrc); i++) begin
            irq_x_o[i] = is_pend_s[i] & enable_i[i];
        end
    end

    assign pending_o = |irq_x_o;
    assign ack_err_o = ack_err_q;

endmodule

// File: tb/tb_ibex_irq_x_ctrl.sv
// Self-checking bench for ibex_irq_x_ctrl: directed scenarios followed by random traffic,
// all checked against a bit-vector reference model of pending / awaiting-drop sources.
module tb_ibex_irq_x_ctrl;

    localparam int          N  = 12;
    localparam logic [15:0] EM = 16'h0101;
`ifdef IBEX_IRQ_X_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  src;
    logic [N-1:0]  en;
    logic          ack;
    logic [3:0]    ack_id;
    logic [31:0]   irq;
    logic          err;
    logic          pend_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending set, level sources waiting for their line to drop.
    logic [N-1:0] m_pend, m_wait, m_prev, m_sh1, m_sh2;
    logic         m_err;

    always #5 clk = ~clk;

    ibex_irq_x_ctrl #(.NumSrc(N), .EdgeMask(EM)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .src_i          (src),
        .enable_i       (en),
        .irq_x_o        (irq),
        .irq_x_ack_i    (ack),
        .irq_x_ack_id_i (ack_id),
        .ack_err_o      (err),
        .pending_o      (pend_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_wait = '0; m_prev = '0; m_sh1 = '0; m_sh2 = '0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s, rise, hit, edge_m, edge_next, lvl_next;
        s      = (LAT == 0) ? src : m_sh2;
        rise   = s & ~m_prev;
        edge_m = EM[N-1:0];
        hit    = '0;
        for (int i = 0; i < N; i++) begin
            if (ack && ack_id == 4'(i) && m_pend[i]) hit[i] = 1'b1;
        end
        edge_next = (m_pend & ~hit) | (rise & en);
        lvl_next  = (m_pend & ~hit) | (~m_pend & ~m_wait & s & en);
        m_err  = ack & ~(|hit);
        m_wait = ~edge_m & ((m_wait & s) | hit);
        m_pend = (edge_m & edge_next) | (~edge_m & lvl_next);
        m_prev = s;
        m_sh2  = m_sh1;
        m_sh1  = src;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_irq;
        exp_irq = 32'h0;
        exp_irq[N-1:0] = m_pend & en;
        chk({tag, ".irq"}, irq, exp_irq);
        chk({tag, ".err"}, {31'h0, err}, {31'h0, m_err});
        chk({tag, ".pend"}, {31'h0, pend_o}, {31'h0, |exp_irq});
    endtask

    task automatic tick(input logic a, input logic [3:0] id);
        ack = a; ack_id = id;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0; ack_id = 4'h0;
        check_model("step");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0; src = '0; en = 12'hF7F; ack = 1'b0; ack_id = 4'h0;
        model_reset();
        #12;
        chk("reset.irq", irq, 32'h0);
        chk("reset.err", {31'h0, err}, 32'h0);
        chk("reset.pend", {31'h0, pend_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Level source 3: latency, ack, no re-request while high, re-raise.
        src[3] = 1'b1;
        idle(1 + LAT);
        chk("lvl.raise", irq, 32'h8);
        idle(1);
        tick(1'b1, 4'd3);
        chk("lvl.ack", irq, 32'h0);
        idle(3);
        chk("lvl.held", irq, 32'h0);
        src[3] = 1'b0;
        idle(1 + LAT);
        src[3] = 1'b1;
        idle(1 + LAT);
        chk("lvl.reraise", irq, 32'h8);
        tick(1'b1, 4'd3);
        src[3] = 1'b0;
        idle(LAT + 2);

        // Edge source 0: pulse latches; rise coincident with ack keeps it pending.
        src[0] = 1'b1;
        tick(1'b0, 4'h0);
        src[0] = 1'b0;
        idle(LAT + 3);
        chk("edge.held", irq, 32'h1);
        src[0] = 1'b1;
        idle(LAT);
        tick(1'b1, 4'd0);
        src[0] = 1'b0;
        chk("edge.setwins", irq, 32'h1);
        idle(LAT + 1);
        tick(1'b1, 4'd0);
        chk("edge.retire", irq, 32'h0);

        // Illegal acks: idle source and out-of-range ID.
        tick(1'b1, 4'd5);
        chk("err.idle", {31'h0, err}, 32'h1);
        idle(1);
        chk("err.pulse", {31'h0, err}, 32'h0);
        tick(1'b1, 4'd12);
        chk("err.range", {31'h0, err}, 32'h1);
        idle(1);
        chk("err.range_pulse", {31'h0, err}, 32'h0);

        // Enable masking on source 2, disabled source 7.
        src[2] = 1'b1;
        idle(1 + LAT);
        en[2] = 1'b0;
        #1;
        chk("en.mask_irq", irq, 32'h0);
        chk("en.mask_pend", {31'h0, pend_o}, 32'h0);
        idle(2);
        en[2] = 1'b1;
        #1;
        chk("en.reenable", irq, 32'h4);
        src[7] = 1'b1;
        idle(LAT + 3);
        chk("en.disabled7", irq & 32'h80, 32'h0);
        tick(1'b1, 4'd2);
        src[2] = 1'b0; src[7] = 1'b0;
        idle(LAT + 2);

        // Asynchronous reset with sources 1 and 4 pending.
        src[1] = 1'b1; src[4] = 1'b1;
        idle(1 + LAT);
        chk("rst.before", irq, 32'h12);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_irq", irq, 32'h0);
        chk("rst.async_pend", {31'h0, pend_o}, 32'h0);
        model_reset();
        src = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(LAT + 3);
        chk("rst.after", irq, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       a;
            logic [3:0] id;
            src = N'($urandom);
            if ($urandom_range(0, 15) == 0) en = N'($urandom);
            a  = ($urandom_range(0, 2) == 0);
            id = 4'($urandom_range(0, 15));
            if (a && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i]) id = 4'(i);
                end
            end
            tick(a, id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_irq_x_ctrl.md
# ibex_irq_x_ctrl

Interrupt source controller that drives the core's `irq_x_i` vector and consumes its `irq_x_ack_o` / `irq_x_ack_id_o` acknowledge. It sits outside `ibex_core`, next to the platform peripherals. Per source, it latches level or edge requests into a pending state and presents enabled pending requests to the core. It retires a request when the core acknowledges that source ID.

## Interface
Parameters:
- `NumSrc`, 16: number of sources, legal range 1..16; ack ID is 4 bits.
- `EdgeMask`, 16'h0000: bit i = 1 makes source i rising-edge sensitive; bit i = 0 makes it level-high sensitive. Bits ≥ `NumSrc` are ignored.

Ports:
- `clk_i` in, 1: clock; the single clock domain.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `src_i` in, `NumSrc`: raw interrupt requests from peripherals.
- `enable_i` in, `NumSrc`: per-source enable; quasi-static.
- `irq_x_o` out, 32: request vector to the core's `irq_x_i`.
- `irq_x_ack_i` in, 1: single-cycle acknowledge strobe from the core.
- `irq_x_ack_id_i` in, 4: ID of the acknowledged source, valid with the strobe.
- `ack_err_o` out, 1: one-cycle pulse when an ack targets an illegal or non-pending source.
- `pending_o` out, 1: OR of all enabled pending sources.

## Operation
- Each source has its own 3-state FSM: IDLE, PENDING, SERVICE. All state resets to IDLE.
- Conditioned input `s_i`: `src_i[i]` directly, or synchronized when the sync feature is compiled in.
- Edge detect: `rise_i = s_i & ~s_prev_i`. `s_prev` resets to 0, so a source high out of reset counts as an edge on the first cycle.
- IDLE → PENDING:
  - Level source: when `s_i` is high and `enable_i[i]` is high.
  - Edge source: when `rise_i` is high and `enable_i[i]` is high.
  - Requests arriving while disabled are dropped.
- PENDING → SERVICE (level source): valid ack with ID i.
- PENDING → IDLE (edge source): valid ack with ID i.
- Edge source, `rise_i` in the same cycle as its ack: the source stays PENDING; set wins.
- SERVICE → IDLE (level only): when `s_i` is low. There is no re-request while the line stays high after the ack.
- Valid ack: `irq_x_ack_i` high, `irq_x_ack_id_i` < `NumSrc`, and that source is in PENDING.
- Any other ack causes no state change and sets `ack_err_o` high for exactly the next cycle.
- Deasserting `enable_i[i]` while PENDING keeps the state but masks the output. Re-enabling re-presents the request.
- `irq_x_o[i]` = (state_i == PENDING) & `enable_i[i]` for i < `NumSrc`.
- `irq_x_o[31:NumSrc]` is constant 0.
- `pending_o` = OR of `irq_x_o`.
- Priority is left to the core; the controller never arbitrates. Each ack retires exactly one source.

## Timing
- Reset values: `irq_x_o` = 0, `ack_err_o` = 0, `pending_o` = 0; all FSMs IDLE; all edge and sync flops 0.
- Request latency without sync: `src_i` sampled high at edge N → state PENDING after edge N, so `irq_x_o` is high in cycle N+1.
- Request latency with sync: 2 further cycles (N+3).
- Ack latency: ack sampled at edge M → `irq_x_o[i]` low from cycle M+1.
- `ack_err_o`: registered, high in cycle M+1 only.
- `irq_x_o` is combinational from FSM flops and `enable_i`. There is no combinational path from `irq_x_ack_i` to any output.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous) and all pending requests are lost.

## Configuration
- `IBEX_IRQ_X_SYNC_EN` defined: every `src_i` bit passes through a 2-flop synchronizer (reset 0) before edge detect and FSM. Request latency is 3 cycles; sources may be asynchronous.
- `IBEX_IRQ_X_SYNC_EN` undefined: `src_i` is used directly. Request latency is 1 cycle; sources must be synchronous to `clk_i`.

## Test plan
- Reset, no sync, `NumSrc`=16, `EdgeMask`=0, all enabled: hold `src_i[3]` high from cycle 5 → `irq_x_o`=32'h8 from cycle 6.
  - Ack ID 3 at cycle 8 → `irq_x_o`=0 from cycle 9; stays 0 while the source is high.
  - Drop the source, re-raise it → pending again 1 cycle later.
- Edge source 0 (`EdgeMask`=16'h1): pulse `src_i[0]` for 1 cycle → `irq_x_o[0]` high and held.
  - Second rising edge coincident with the ack of ID 0 → `irq_x_o[0]` still high after the ack.
- Ack ID 5 while source 5 is IDLE, and ack ID 12 with `NumSrc`=8 → `ack_err_o` is a 1-cycle pulse each time; `irq_x_o` unchanged.
- Source 2 pending, `enable_i[2]` driven 0 → `irq_x_o[2]`=0 and `pending_o`=0.
  - Re-enable → `irq_x_o[2]`=1 with no new request needed.
  - Source 7 raised while disabled → never pending.
- Sources 1 and 4 pending; assert `rst_ni` low mid-cycle → outputs 0 asynchronously, before the next clock edge. After release with sources low → remains 0.
- With `IBEX_IRQ_X_SYNC_EN` defined: `src_i[9]` rising at edge N → `irq_x_o[9]` high in cycle N+3, not earlier.
